// File: rtl/rpc2_ctrl_xfer_scheduler.sv
// Round-robin write/read request scheduler for the Xccela PSRAM sequencer: splits each
// granted request on page and CE#-low beat limits and spaces transactions by a CE#-high gap.
module rpc2_ctrl_xfer_scheduler #(
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned LEN_W      = 12,
  parameter int unsigned PAGE_BYTES = 1024,
  parameter int unsigned MAX_BEATS  = 64,
  parameter int unsigned CE_GAP     = 3
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              wr_req_valid,
  output logic              wr_req_ready,
  input  logic [ADDR_W-1:0] wr_req_addr,
  input  logic [LEN_W-1:0]  wr_req_len,
  input  logic              rd_req_valid,
  output logic              rd_req_ready,
  input  logic [ADDR_W-1:0] rd_req_addr,
  input  logic [LEN_W-1:0]  rd_req_len,
  output logic              cmd_valid,
  input  logic              cmd_ready,
  output logic              cmd_wr,
  output logic [ADDR_W-1:0] cmd_addr,
  output logic [LEN_W-1:0]  cmd_len,
  output logic              cmd_last,
  input  logic              seq_done,
  output logic              busy
);

  localparam int unsigned CNT_W = LEN_W + 1;
  localparam int unsigned OFF_W = $clog2(PAGE_BYTES);
  localparam int unsigned PL_W  = OFF_W + 1;
  localparam int unsigned MW    = (CNT_W > OFF_W) ? CNT_W : OFF_W;
  localparam int unsigned GAP_W = (CE_GAP > 1) ? $clog2(CE_GAP) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CALC,
    S_ISSUE,
    S_WAIT_DONE,
    S_GAP
  } state_t;

  state_t             r_state;
  logic [ADDR_W-1:0]  r_addr;
  logic [CNT_W-1:0]   r_remaining;
  logic               r_last_wr;
  logic [GAP_W-1:0]   r_gap_cnt;

  logic               w_idle;
  logic               w_grant_wr;
  logic               w_grant_rd;
  logic [PL_W-1:0]    w_page_left;
  logic [MW-1:0]      w_page_beats;
  logic [MW-1:0]      w_rem_m;
  logic [MW-1:0]      w_max_m;
  logic [MW-1:0]      w_chunk_m;
  logic [CNT_W-1:0]   w_chunk;
  logic [ADDR_W-1:0]  w_chunk_bytes;
  state_t             w_post_gap;

  // Grant: a lone requester wins; on a tie the side not served last time wins.
  assign w_idle       = (r_state == S_IDLE);
  assign w_grant_wr   = w_idle & wr_req_valid & (~rd_req_valid | ~r_last_wr);
  assign w_grant_rd   = w_idle & rd_req_valid & (~wr_req_valid | r_last_wr);
  assign wr_req_ready = w_grant_wr;
  assign rd_req_ready = w_grant_rd;
  assign busy         = ~w_idle;

  // Chunk = min(remaining, tCEM budget, beats left in the current page).
  assign w_page_left  = PL_W'(PAGE_BYTES) - {1'b0, r_addr[OFF_W-1:0]};
  assign w_page_beats = MW'(w_page_left >> 1);
  assign w_rem_m      = MW'(r_remaining);
  assign w_max_m      = MW'(MAX_BEATS);

  always_comb begin
    w_chunk_m = w_rem_m;
    if (w_max_m < w_chunk_m) begin
      w_chunk_m = w_max_m;
    end
    if (w_page_beats < w_chunk_m) begin
      w_chunk_m = w_page_beats;
    end
  end

  assign w_chunk       = CNT_W'(w_chunk_m);
  assign w_chunk_bytes = ADDR_W'({w_chunk, 1'b0});
  assign w_post_gap    = (r_remaining != '0) ? S_CALC : S_IDLE;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= S_IDLE;
      r_addr      <= '0;
      r_remaining <= '0;
      r_last_wr   <= 1'b0;
      r_gap_cnt   <= '0;
      cmd_valid   <= 1'b0;
      cmd_wr      <= 1'b0;
      cmd_addr    <= '0;
      cmd_len     <= '0;
      cmd_last    <= 1'b0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (w_grant_wr | w_grant_rd) begin
            r_addr      <= (w_grant_wr ? wr_req_addr : rd_req_addr) & ~ADDR_W'(1);
            r_remaining <= CNT_W'(w_grant_wr ? wr_req_len : rd_req_len) + CNT_W'(1);
            cmd_wr      <= w_grant_wr;
            r_last_wr   <= w_grant_wr;
            r_state     <= S_CALC;
          end
        end
        S_CALC: begin
          cmd_addr    <= r_addr;
          cmd_len     <= LEN_W'(w_chunk - CNT_W'(1));
          cmd_last    <= (w_chunk == r_remaining);
          r_addr      <= r_addr + w_chunk_bytes;
          r_remaining <= r_remaining - w_chunk;
          cmd_valid   <= 1'b1;
          r_state     <= S_ISSUE;
        end
        S_ISSUE: begin
          if (cmd_ready) begin
            cmd_valid <= 1'b0;
            r_state   <= S_WAIT_DONE;
          end
        end
        S_WAIT_DONE: begin
          if (seq_done) begin
            if (CE_GAP == 0) begin
              r_state <= w_post_gap;
            end else begin
              r_gap_cnt <= GAP_W'(CE_GAP - 1);
              r_state   <= S_GAP;
            end
          end
        end
        S_GAP: begin
          if (r_gap_cnt == '0) begin
            r_state <= w_post_gap;
          end else begin
            r_gap_cnt <= r_gap_cnt - GAP_W'(1);
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rpc2_ctrl_xfer_scheduler.sv
// Randomized scoreboard bench for rpc2_ctrl_xfer_scheduler: a reference model predicts
// grants, split commands and their timing; a monitor compares every cycle.
module tb_rpc2_ctrl_xfer_scheduler;

  localparam int unsigned ADDR_W     = 32;
  localparam int unsigned LEN_W      = 12;
  localparam int unsigned PAGE_BYTES = 1024;
  localparam int unsigned MAX_BEATS  = 64;
  localparam int unsigned CE_GAP     = 3;
  localparam int          INF        = 32'h7fff_ffff;

  logic              clk;
  logic              reset_n;
  logic              wr_req_valid, wr_req_ready, rd_req_valid, rd_req_ready;
  logic [ADDR_W-1:0] wr_req_addr, rd_req_addr, cmd_addr;
  logic [LEN_W-1:0]  wr_req_len, rd_req_len, cmd_len;
  logic              cmd_valid, cmd_ready, cmd_wr, cmd_last, seq_done, busy;

  typedef struct packed {
    logic [31:0] addr;
    logic [11:0] len;
  } req_t;

  typedef struct packed {
    logic        wr;
    logic [31:0] addr;
    logic [11:0] len;
    logic        last;
  } cmd_t;

  req_t wq[$];
  req_t rq[$];
  cmd_t exp_q[$];
  cmd_t cur;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int idle_from = 0;
  int next_valid_cyc = 0;
  bit m_last_wr = 0, awaiting_cmd = 0, awaiting_done = 0, cur_last = 0;
  bit prev_valid = 0, prev_hs = 0, m_quiet = 0;
  bit rand_mode = 0, bp_arm = 0;

  rpc2_ctrl_xfer_scheduler #(
    .ADDR_W(ADDR_W), .LEN_W(LEN_W), .PAGE_BYTES(PAGE_BYTES),
    .MAX_BEATS(MAX_BEATS), .CE_GAP(CE_GAP)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .wr_req_valid(wr_req_valid), .wr_req_ready(wr_req_ready),
    .wr_req_addr(wr_req_addr), .wr_req_len(wr_req_len),
    .rd_req_valid(rd_req_valid), .rd_req_ready(rd_req_ready),
    .rd_req_addr(rd_req_addr), .rd_req_len(rd_req_len),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_wr(cmd_wr),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len), .cmd_last(cmd_last),
    .seq_done(seq_done), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference split: walk the request in page/tCEM-limited pieces.
  function automatic void push_chunks(input bit wr, input logic [31:0] a, input logic [11:0] l);
    int unsigned rem, pb, c;
    logic [31:0] ad;
    rem = 32'(l) + 1;
    ad  = a & ~32'd1;
    while (rem > 0) begin
      pb = (PAGE_BYTES - (ad % PAGE_BYTES)) / 2;
      c  = rem;
      if (c > MAX_BEATS) c = MAX_BEATS;
      if (c > pb) c = pb;
      exp_q.push_back('{wr, ad, 12'(c - 1), (c == rem)});
      ad  = ad + 32'(2 * c);
      rem = rem - c;
    end
  endfunction

  // Monitor / scoreboard
  always @(negedge clk) begin
    bit ew, er, idle_now;
    cyc++;
    if (!reset_n) begin
      chk("reset_outputs", 64'(|{wr_req_ready, rd_req_ready, cmd_valid, cmd_wr, cmd_addr,
                                 cmd_len, cmd_last, busy}), 64'd0);
      exp_q.delete();
      m_last_wr = 0; idle_from = 0; awaiting_cmd = 0; awaiting_done = 0;
      prev_valid = 0; prev_hs = 0;
    end else begin
      idle_now = (cyc >= idle_from);
      chk("busy", 64'(busy), 64'(!idle_now));
      if (seq_done && awaiting_done) begin
        awaiting_done = 0;
        if (cur_last) idle_from = cyc + int'(CE_GAP) + 1;
        else begin
          next_valid_cyc = cyc + int'(CE_GAP) + 2;
          awaiting_cmd   = 1;
        end
      end
      ew = idle_now && wr_req_valid && (!rd_req_valid || !m_last_wr);
      er = idle_now && rd_req_valid && (!wr_req_valid || m_last_wr);
      chk("wr_req_ready", 64'(wr_req_ready), 64'(ew));
      chk("rd_req_ready", 64'(rd_req_ready), 64'(er));
      if (ew || er) begin
        m_last_wr = ew;
        if (ew) push_chunks(1'b1, wr_req_addr, wr_req_len);
        else    push_chunks(1'b0, rd_req_addr, rd_req_len);
        idle_from      = INF;
        next_valid_cyc = cyc + 2;
        awaiting_cmd   = 1;
      end
      if (prev_hs) chk("cmd_valid_drop", 64'(cmd_valid), 64'd0);
      if (cmd_valid && !prev_valid) begin
        chk("cmd_expected", 64'(awaiting_cmd), 64'd1);
        chk("cmd_rise_cycle", 64'(cyc), 64'(next_valid_cyc));
        awaiting_cmd = 0;
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL cmd_extra actual=cmd@%0h required=no_cmd (cycle %0d)", cmd_addr, cyc);
          cur = '0;
        end else begin
          cur = exp_q.pop_front();
        end
      end
      if (cmd_valid) begin
        chk("cmd_wr", 64'(cmd_wr), 64'(cur.wr));
        chk("cmd_addr", 64'(cmd_addr), 64'(cur.addr));
        chk("cmd_len", 64'(cmd_len), 64'(cur.len));
        chk("cmd_last", 64'(cmd_last), 64'(cur.last));
      end
      if (!cmd_valid && awaiting_cmd && cyc > next_valid_cyc) begin
        checks++; errors++;
        $display("FAIL cmd_timeout actual=no_cmd required=cmd_valid@%0d (cycle %0d)",
                 next_valid_cyc, cyc);
        awaiting_cmd = 0;
      end
      prev_hs = cmd_valid && cmd_ready;
      if (prev_hs) begin
        awaiting_done = 1;
        cur_last      = cur.last;
      end
      prev_valid = cmd_valid && !cmd_ready;
    end
    m_quiet = reset_n && (cyc >= idle_from) && !awaiting_cmd && !awaiting_done &&
              (exp_q.size() == 0);
  end

  // Write requester
  initial begin
    bit g; int gap;
    wr_req_valid = 0; wr_req_addr = '0; wr_req_len = '0; gap = 0;
    forever begin
      @(negedge clk); g = wr_req_ready;
      @(posedge clk); #1;
      if (!reset_n) wr_req_valid = 0;
      else begin
        if (g && wr_req_valid) begin
          void'(wq.pop_front());
          wr_req_valid = 0;
          gap = rand_mode ? int'($urandom_range(0, 3)) : 0;
        end
        if (!wr_req_valid) begin
          if (gap > 0) gap--;
          else if (wq.size() != 0) begin
            wr_req_valid = 1; wr_req_addr = wq[0].addr; wr_req_len = wq[0].len;
          end
        end
      end
    end
  end

  // Read requester
  initial begin
    bit g; int gap;
    rd_req_valid = 0; rd_req_addr = '0; rd_req_len = '0; gap = 0;
    forever begin
      @(negedge clk); g = rd_req_ready;
      @(posedge clk); #1;
      if (!reset_n) rd_req_valid = 0;
      else begin
        if (g && rd_req_valid) begin
          void'(rq.pop_front());
          rd_req_valid = 0;
          gap = rand_mode ? int'($urandom_range(0, 3)) : 0;
        end
        if (!rd_req_valid) begin
          if (gap > 0) gap--;
          else if (rq.size() != 0) begin
            rd_req_valid = 1; rd_req_addr = rq[0].addr; rd_req_len = rq[0].len;
          end
        end
      end
    end
  end

  // Sequencer stand-in: random ready, delayed done, optional spurious done and backpressure.
  initial begin
    bit cv, hs, bp_used; int dcnt, bp_left;
    cmd_ready = 0; seq_done = 0; dcnt = -1; bp_left = 0; bp_used = 0;
    forever begin
      @(negedge clk); cv = cmd_valid; hs = cmd_valid && cmd_ready;
      @(posedge clk); #1;
      seq_done = 0;
      if (!reset_n) begin
        cmd_ready = 0; dcnt = -1;
      end else begin
        if (hs) dcnt = int'($urandom_range(0, 5));
        if (dcnt == 0) begin seq_done = 1; dcnt = -1; end
        else if (dcnt > 0) dcnt--;
        else if (rand_mode && $urandom_range(0, 15) == 0) seq_done = 1;
        if (bp_arm && !bp_used) begin
          cmd_ready = 0;
          if (cv) begin bp_used = 1; bp_left = 9; end
        end else if (bp_left > 0) begin
          cmd_ready = 0;
          bp_left--;
          if (bp_left == 4) seq_done = 1;
        end else begin
          cmd_ready = ($urandom_range(0, 2) != 0);
        end
      end
    end
  end

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    while (!(m_quiet && wq.size() == 0 && rq.size() == 0 && !wr_req_valid && !rd_req_valid)
           && n < budget) begin
      @(posedge clk); #2;
      n++;
    end
    chk("drain_within_budget", 64'(n < budget), 64'd1);
  endtask

  initial begin
    logic [31:0] a;
    int unsigned l;
    int n;
    reset_n = 0;
    wq.push_back('{32'h100, 12'd0}); wq.push_back('{32'h200, 12'd0});
    rq.push_back('{32'h300, 12'd0}); rq.push_back('{32'h400, 12'd0});
    repeat (3) @(negedge clk);
    #2 reset_n = 1;
    wait_idle(500);

    wq.push_back('{32'h3F8, 12'd7});
    wait_idle(500);
    rq.push_back('{32'h0, 12'd255});
    wait_idle(1000);

    bp_arm = 1;
    wq.push_back('{32'h1000, 12'd9});
    wait_idle(500);
    bp_arm = 0;

    rand_mode = 1;
    for (int i = 0; i < 40; i++) begin
      a = $urandom();
      case ($urandom_range(0, 3))
        0: a[9:0] = 10'(1024 - 2 * $urandom_range(1, 8));
        1: a = 32'hFFFF_FFF8;
        default: ;
      endcase
      l = $urandom_range(0, 150);
      if ($urandom_range(0, 1) == 0) wq.push_back('{a, 12'(l)});
      else                           rq.push_back('{a, 12'(l)});
    end
    wait_idle(20000);
    rand_mode = 0;

    // Abort a 4-chunk write while it waits for seq_done on its second chunk.
    wq.push_back('{32'h0, 12'd255});
    n = 0;
    while (!(awaiting_done && exp_q.size() == 2) && n < 2000) begin
      @(posedge clk); #1;
      n++;
    end
    chk("reach_wait_done", 64'(n < 2000), 64'd1);
    reset_n = 0;
    repeat (3) @(negedge clk);
    wq.push_back('{32'h2000, 12'd0});
    rq.push_back('{32'h3000, 12'd1});
    #2 reset_n = 1;
    wait_idle(500);
    rq.push_back('{32'h5000, 12'd3});
    wait_idle(500);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
